// File: rtl/return_stack_pkg.sv
// return_stack_pkg: shared microc constants, call/return opcodes and stack-op decode.
package return_stack_pkg;
  localparam int RS_AW = 10;
  localparam int RS_DEPTH = 16;
  localparam int RS_LW = 5;
  typedef enum logic [3:0] {
    OP_JAL = 4'hE,
    OP_RET = 4'hF
  } microc_op_e;
  typedef enum logic [1:0] {
    SOP_HOLD,
    SOP_PUSH,
    SOP_POP,
    SOP_REPL
  } stack_op_e;
  // A push+pop on an empty stack degrades to a plain push; a lone push when full is dropped.
  function automatic stack_op_e decode_op(input logic push, input logic pop, input logic empty,
                                          input logic full);
    return (push && pop && !empty) ? SOP_REPL :
           (push && !full)         ? SOP_PUSH :
           (pop && !push && !empty) ? SOP_POP : SOP_HOLD;
  endfunction
endpackage

// File: rtl/return_stack_regfile.sv
// return_stack_regfile: DEPTH x AW storage, one synchronous write port, one combinational read port.
module return_stack_regfile #(
  parameter int AW = 10,
  parameter int DEPTH = 16,
  parameter int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [AW-1:0] wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [AW-1:0] rdata_o
);
  logic [AW-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses for jal/ret with level status and sticky error flags.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int AW = RS_AW,
  parameter int DEPTH = RS_DEPTH,
  parameter int LW = RS_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] din_i,
  input  logic          clr_err_i,
  output logic [AW-1:0] dout_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [LW-1:0] level_o,
  output logic          overflow_o,
  output logic          underflow_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int SPW = IW + 1;
  localparam logic [SPW-1:0] ONE = SPW'(1);
  logic [SPW-1:0] sp_q, sp_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic empty, full, we;
  logic [IW-1:0] top_idx, waddr;
  logic [AW-1:0] rdata;
  stack_op_e op;
  assign empty = sp_q == '0;
  assign full = sp_q == SPW'(DEPTH);
  assign op = decode_op(push_i, pop_i, empty, full);
  assign top_idx = IW'(sp_q - ONE);
  assign waddr = (op == SOP_REPL) ? top_idx : IW'(sp_q);
  assign we = (op == SOP_PUSH) || (op == SOP_REPL);
  always_comb begin
    sp_d = (op == SOP_PUSH) ? sp_q + ONE : (op == SOP_POP) ? sp_q - ONE : sp_q;
    ovf_d = (push_i && !pop_i && full) || (ovf_q && !clr_err_i);
    unf_d = (pop_i && empty) || (unf_q && !clr_err_i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sp_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  return_stack_regfile #(.AW(AW), .DEPTH(DEPTH)) u_regfile (
    .clk(clk),
    .we_i(we),
    .waddr_i(waddr),
    .wdata_i(din_i),
    .raddr_i(top_idx),
    .rdata_o(rdata)
  );
  assign dout_o = empty ? '0 : rdata;
  assign empty_o = empty;
  assign full_o = full;
  assign level_o = LW'(sp_q);
  assign overflow_o = ovf_q;
  assign underflow_o = unf_q;
endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware return-address stack (LIFO) for the microc subroutine extension, used by the `jal` and `ret` opcodes.
- Sits directly upstream of the PC register, alongside the PC-select mux.
  - On call, the control unit pushes PC+1.
  - On return, the top entry is the next-PC source.
- Driven by new control-unit strobes `s_push`/`s_pop`. Reports status back for an error trap.

Parameters:
AW, 10, PC/address width in bits
DEPTH, 16, number of stack entries (power of two, ≥2)
LW, 5, width of level output; must satisfy 2^LW > DEPTH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
push  input  1  push din this cycle (from control unit, `jal`)
pop  input  1  pop top entry this cycle (from control unit, `ret`)
din  input  AW  return address to push (PC+1 from datapath)
clr_err  input  1  synchronous clear of sticky error flags
dout  output  AW  current top-of-stack, combinational from state
empty  output  1  level == 0
full  output  1  level == DEPTH
level  output  LW  number of valid entries
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Clock and reset: one clock `clk`. `reset` is asynchronous and active-low.
  - While `reset`=0: sp=0, level=0, empty=1, full=0, overflow=0, underflow=0, dout=0.
  - Memory contents are not reset; reads are masked by `empty`.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Storage: DEPTH×AW register array. sp points to the next free slot. Top = mem[sp-1].
- dout:
  - Equals mem[sp-1] when not empty, 0 when empty.
  - Combinational from registered state, so the PC can load it on the same edge the pop is applied.
- Zero-latency read: a value pushed in cycle N is visible on dout from cycle N+1.
- Operation table, evaluated at the rising edge:
  - push only, not full: mem[sp] <= din; sp <= sp+1.
  - push only, full: no state change; overflow <= 1.
  - pop only, not empty: sp <= sp-1.
  - pop only, empty: no state change; underflow <= 1.
  - push & pop, not empty: replace top (tail-call). mem[sp-1] <= din; sp unchanged; no flags.
  - push & pop, empty: treated as push only (mem[0] <= din, sp <= 1); underflow <= 1.
  - push & pop, full: replace top; no overflow.
  - neither: hold.
- Error flags:
  - Sticky until `clr_err`=1 at a clock edge.
  - If `clr_err` and a new error occur in the same cycle, the new error wins (flag stays 1).
- sp arithmetic:
  - Width clog2(DEPTH)+1, never wraps.
  - Full/empty are decided on level, not on pointer equality.
- No X propagation: push/pop sampled only at the edge; unknown inputs are not a supported condition.

Decomposition:
- Shared package/include (microc_defs):
  - AW default value.
  - New opcodes OP_JAL and OP_RET.
  - Stack DEPTH constant, so the control unit and datapath agree.
- One natural sub-module: `stack_regfile`.
  - DEPTH×AW storage.
  - One synchronous write port (waddr, wdata, we).
  - One combinational read port (raddr).
- `return_stack` holds sp, the operation decode and the flag logic.

Test Plan:
- Reset: hold reset=0 with push=1, din=10'h155 for 3 cycles → empty=1, level=0, dout=0, overflow=underflow=0. Release reset → still empty.
- LIFO order: push 10'h001, 10'h002, 10'h003 on consecutive cycles.
  - level=3, dout=10'h003.
  - Pop three times → dout sequence 10'h002, 10'h001, 0; empty=1 after the last pop.
- Overflow: push 16 values 10'h100+i → full=1, level=16.
  - 17th push of 10'h3FF → overflow=1, level=16, dout=10'h10F.
  - Pulse clr_err → overflow=0.
- Underflow: pop on empty → underflow=1, level=0.
  - Then push & pop together with din=10'h0AA → level=1, dout=10'h0AA, underflow=1.
- Tail-call: with entries {10'h010, 10'h020}, assert push & pop with din=10'h030 → level=2, dout=10'h030.
  - Pop → dout=10'h010.
- Async reset mid-run: with level=5, drop reset between clock edges → level=0 and empty=1 before the next rising edge.
  - After release, push 10'h007 → dout=10'h007, level=1.
